// File: rtl/axi_ofm_writer.sv
// AXI4 write initiator: buffers the OFM stream in a FIFO and writes it to DRAM as
// INCR bursts that never cross 4 KB. Optional stall counter under OFM_WR_PERF_EN.
module axi_ofm_writer #(
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_ID = 4,
  parameter int AXI_WIDTH_DA = 32,
  parameter int BURST_LEN    = 16,
  parameter int FIFO_DEPTH   = 32,
  parameter int CNT_W        = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [AXI_WIDTH_AD-1:0]   i_base_addr,
  input  logic [CNT_W-1:0]          i_num_words,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [AXI_WIDTH_DA-1:0]   s_data,
  output logic                      M_AWVALID,
  input  logic                      M_AWREADY,
  output logic [AXI_WIDTH_AD-1:0]   M_AWADDR,
  output logic [AXI_WIDTH_ID-1:0]   M_AWID,
  output logic [7:0]                M_AWLEN,
  output logic [2:0]                M_AWSIZE,
  output logic [1:0]                M_AWBURST,
  output logic                      M_WVALID,
  input  logic                      M_WREADY,
  output logic [AXI_WIDTH_DA-1:0]   M_WDATA,
  output logic [AXI_WIDTH_DA/8-1:0] M_WSTRB,
  output logic                      M_WLAST,
  input  logic                      M_BVALID,
  output logic                      M_BREADY,
  input  logic [1:0]                M_BRESP,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err,
  output logic [2:0]                o_dbg_state
`ifdef OFM_WR_PERF_EN
  ,
  output logic [31:0]               o_stall_cycles
`endif
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both
  // high; once valid rises, it and its payload stay stable until that transfer.

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_RESP = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [AXI_WIDTH_DA-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;

  logic [AXI_WIDTH_AD-1:0] addr_q;
  logic [CNT_W-1:0]        rem_q;
  logic [CNT_W-1:0]        rem_next;
  logic [8:0]              len_q;
  logic [8:0]              beat_q;
  logic                    err_q;

  logic                    start_acc;
  logic                    push;
  logic                    pop;
  logic                    last_beat;
  logic [10:0]             words_to_4k;
  logic [31:0]             len_w;
  logic [8:0]              len_c;

  assign start_acc = (state_q == S_IDLE) && i_start;
  assign o_busy    = (state_q == S_CALC) || (state_q == S_ADDR) ||
                     (state_q == S_DATA) || (state_q == S_RESP);
  assign s_ready   = (count < CW'(FIFO_DEPTH)) && o_busy;
  assign push      = s_valid && s_ready;
  assign pop       = M_WVALID && M_WREADY;
  assign last_beat = (beat_q == len_q - 9'd1);
  assign rem_next  = rem_q - CNT_W'(len_q);

  // Burst length: smallest of the burst cap, the words left, and the words to the next 4 KB page.
  always_comb begin
    words_to_4k = 11'd1024 - {1'b0, addr_q[11:2]};
    len_w = 32'(BURST_LEN);
    if (32'(rem_q) < len_w)       len_w = 32'(rem_q);
    if (32'(words_to_4k) < len_w) len_w = 32'(words_to_4k);
    len_c = len_w[8:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    M_AWVALID = 1'b0;
    M_WVALID  = 1'b0;
    M_WLAST   = 1'b0;
    M_BREADY  = 1'b0;
    o_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = (i_num_words == '0) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        // Start only once the whole burst is buffered, so WVALID never drops mid-burst.
        if (32'(count) >= 32'(len_c)) state_d = S_ADDR;
      end
      S_ADDR: begin
        M_AWVALID = 1'b1;
        if (M_AWREADY) state_d = S_DATA;
      end
      S_DATA: begin
        M_WVALID = 1'b1;
        M_WLAST  = last_beat;
        if (M_WREADY && last_beat) state_d = S_RESP;
      end
      S_RESP: begin
        M_BREADY = 1'b1;
        if (M_BVALID) state_d = (rem_next == '0) ? S_DONE : S_CALC;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
      len_q  <= '0;
      beat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (start_acc) begin
        addr_q <= i_base_addr;
        rem_q  <= i_num_words;
        err_q  <= 1'b0;
      end
      if (state_q == S_CALC && state_d == S_ADDR) begin
        len_q  <= len_c;
        beat_q <= '0;
      end
      if (pop) beat_q <= beat_q + 9'd1;
      if (state_q == S_RESP && M_BVALID) begin
        if (M_BRESP != 2'b00) err_q <= 1'b1;
        addr_q <= addr_q + AXI_WIDTH_AD'({len_q, 2'b00});
        rem_q  <= rem_next;
      end
    end
  end

  // Stream FIFO; a new job discards words left over from the previous one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (start_acc) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  assign M_AWADDR    = addr_q;
  assign M_AWID      = '0;
  assign M_AWLEN     = 8'(len_q - 9'd1);
  assign M_AWSIZE    = 3'b010;
  assign M_AWBURST   = 2'b01;
  assign M_WDATA     = mem[rd_ptr];
  assign M_WSTRB     = '1;
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

`ifdef OFM_WR_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            stall_q <= '0;
    else if (start_acc) stall_q <= '0;
    else if (o_busy && ((state_q == S_CALC) || (M_WVALID && !M_WREADY)))
      stall_q <= stall_q + 32'd1;
  end

  assign o_stall_cycles = stall_q;
`endif

endmodule
